// File: rtl/fifo_w16.sv
// Synchronous 16-bit FIFO with a registered read port, feeding register_w16.
// Define FIFO_W16_ERR_EN to add sticky ovf/udf flags and err_clr.
module fifo_w16 #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
`ifdef FIFO_W16_ERR_EN
   ,
   output logic             ovf,
   output logic             udf,
   input  logic             err_clr
`endif
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;
   logic [AW:0]      count_nxt;

   // A write into a full FIFO is fine when a read frees a slot the same edge
   always_comb begin
      rd_ok     = rd_en && !empty;
      wr_ok     = wr_en && (!full || rd_en);
      count_nxt = count;
      unique case ({wr_ok, rd_ok})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         rd_valid <= rd_ok;
         count    <= count_nxt;
         full     <= (count_nxt == FULL_CNT);
         empty    <= (count_nxt == '0);
      end
   end

   // Storage is never cleared; reset only blocks writes
   always_ff @(posedge clk) begin
      if (rst_n && wr_ok)
         mem[wr_ptr] <= wr_data;
   end

`ifdef FIFO_W16_ERR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wr_en && !wr_ok)
            ovf <= 1'b1;
         else if (err_clr)
            ovf <= 1'b0;
         if (rd_en && !rd_ok)
            udf <= 1'b1;
         else if (err_clr)
            udf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_w16.sv
// Scoreboard bench for fifo_w16; queue model predicts data, flags and count.
// Error-flag checks follow FIFO_W16_ERR_EN.
module tb_fifo_w16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        full;
   logic        empty;
   logic [2:0]  count;
`ifdef FIFO_W16_ERR_EN
   logic        ovf;
   logic        udf;
   logic        err_clr = 1'b0;
   logic        m_ovf = 1'b0;
   logic        m_udf = 1'b0;
`endif

   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] q[$];
   logic [15:0] last_rd = '0;
   logic        exp_v = 1'b0;

   fifo_w16 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .count    (count)
`ifdef FIFO_W16_ERR_EN
      ,
      .ovf      (ovf),
      .udf      (udf),
      .err_clr  (err_clr)
`endif
   );

   always #5 clk = ~clk;

   // One clock of stimulus; model predicts acceptance and moves the scoreboard
   task automatic drive(input logic w, input logic [15:0] d, input logic r);
      logic wa;
      logic ra;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      ra = r && (q.size() != 0);
      wa = w && (q.size() != 4 || r);
      exp_v = ra;
      if (ra) last_rd = q.pop_front();
      if (wa) q.push_back(d);
`ifdef FIFO_W16_ERR_EN
      if (w && !wa) m_ovf = 1'b1;
      else if (err_clr) m_ovf = 1'b0;
      if (r && !ra) m_udf = 1'b1;
      else if (err_clr) m_udf = 1'b0;
`endif
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      last_rd = '0;
      exp_v   = 1'b0;
`ifdef FIFO_W16_ERR_EN
      m_ovf = 1'b0;
      m_udf = 1'b0;
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wr_en = 1'b1;
      wr_data = 16'hDEAD;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      n_chk++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b exp 1", empty); else n_pass++;
      n_chk++; if (full !== 1'b0) $display("FAIL rst_full: got %b exp 0", full); else n_pass++;
      n_chk++; if (count !== 3'd0) $display("FAIL rst_count: got %0d exp 0", count); else n_pass++;
      n_chk++; if (rd_data !== 16'h0) $display("FAIL rst_rd_data: got %h exp 0000", rd_data); else n_pass++;
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b exp 0", rd_valid); else n_pass++;
`ifdef FIFO_W16_ERR_EN
      n_chk++; if (ovf !== 1'b0 || udf !== 1'b0) $display("FAIL rst_flags: got %b%b exp 00", ovf, udf); else n_pass++;
`endif
      wr_en = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_fill_drain();
      logic [15:0] v [4];
      v = '{16'h0005, 16'h000A, 16'h0003, 16'h1234};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, v[i], 1'b0);
         n_chk++; if (count !== 3'(i + 1)) $display("FAIL fd_count: got %0d exp %0d", count, i + 1); else n_pass++;
         n_chk++; if (full !== (i == 3)) $display("FAIL fd_full: got %b exp %b", full, i == 3); else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 16'h0, 1'b1);
         n_chk++; if (rd_valid !== 1'b1) $display("FAIL fd_rd_valid: got %b exp 1", rd_valid); else n_pass++;
         n_chk++; if (rd_data !== last_rd) $display("FAIL fd_rd_data: got %h exp %h", rd_data, last_rd); else n_pass++;
         n_chk++; if (rd_data !== v[i]) $display("FAIL fd_order: got %h exp %h", rd_data, v[i]); else n_pass++;
      end
      n_chk++; if (empty !== 1'b1) $display("FAIL fd_empty: got %b exp 1", empty); else n_pass++;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) drive(1'b1, 16'h0A00 + 16'(i), 1'b0);
      drive(1'b1, 16'hFFFF, 1'b0);
      n_chk++; if (count !== 3'(q.size())) $display("FAIL ovf_count: got %0d exp %0d", count, q.size()); else n_pass++;
      n_chk++; if (full !== 1'b1) $display("FAIL ovf_full: got %b exp 1", full); else n_pass++;
`ifdef FIFO_W16_ERR_EN
      n_chk++; if (ovf !== m_ovf) $display("FAIL ovf_set: got %b exp %b", ovf, m_ovf); else n_pass++;
      err_clr = 1'b1;
      drive(1'b0, 16'h0, 1'b0);
      err_clr = 1'b0;
      n_chk++; if (ovf !== m_ovf) $display("FAIL ovf_clr: got %b exp %b", ovf, m_ovf); else n_pass++;
`endif
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 16'h0, 1'b1);
         n_chk++; if (rd_valid !== exp_v || rd_data !== last_rd) $display("FAIL ovf_read: got %b/%h exp %b/%h", rd_valid, rd_data, exp_v, last_rd); else n_pass++;
      end
   endtask

   task automatic test_underflow();
      drive(1'b0, 16'h0, 1'b1);
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL udf_rd_valid: got %b exp 0", rd_valid); else n_pass++;
      n_chk++; if (rd_data !== last_rd) $display("FAIL udf_rd_data: got %h exp %h", rd_data, last_rd); else n_pass++;
      n_chk++; if (empty !== 1'b1 || count !== 3'd0) $display("FAIL udf_state: got %b/%0d exp 1/0", empty, count); else n_pass++;
`ifdef FIFO_W16_ERR_EN
      n_chk++; if (udf !== m_udf) $display("FAIL udf_set: got %b exp %b", udf, m_udf); else n_pass++;
      err_clr = 1'b1;
      drive(1'b0, 16'h0, 1'b1);
      err_clr = 1'b0;
      n_chk++; if (udf !== m_udf) $display("FAIL udf_set_wins: got %b exp %b", udf, m_udf); else n_pass++;
      err_clr = 1'b1;
      drive(1'b0, 16'h0, 1'b0);
      err_clr = 1'b0;
      n_chk++; if (udf !== m_udf) $display("FAIL udf_clr: got %b exp %b", udf, m_udf); else n_pass++;
`endif
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) drive(1'b1, 16'hB000 + 16'(i), 1'b0);
      drive(1'b1, 16'hBEEF, 1'b1);
      n_chk++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL sim_full_count: got %0d/%b exp 4/1", count, full); else n_pass++;
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== 16'hB000) $display("FAIL sim_full_oldest: got %b/%h exp 1/b000", rd_valid, rd_data); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 16'h0, 1'b1);
         n_chk++; if (rd_valid !== exp_v || rd_data !== last_rd) $display("FAIL sim_drain: got %b/%h exp %b/%h", rd_valid, rd_data, exp_v, last_rd); else n_pass++;
      end
      n_chk++; if (rd_data !== 16'hBEEF) $display("FAIL sim_beef_last: got %h exp beef", rd_data); else n_pass++;
      drive(1'b1, 16'h5A5A, 1'b1);
      n_chk++; if (count !== 3'd1 || rd_valid !== 1'b0) $display("FAIL sim_empty: got %0d/%b exp 1/0", count, rd_valid); else n_pass++;
      drive(1'b0, 16'h0, 1'b1);
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A) $display("FAIL sim_empty_read: got %b/%h exp 1/5a5a", rd_valid, rd_data); else n_pass++;
`ifdef FIFO_W16_ERR_EN
      err_clr = 1'b1;
      drive(1'b0, 16'h0, 1'b0);
      err_clr = 1'b0;
`endif
   endtask

   task automatic test_wrap_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 16'hC000 + 16'(i), i > 0);
         if (i > 0) begin
            n_chk++; if (rd_valid !== exp_v || rd_data !== last_rd) $display("FAIL wrap_read: got %b/%h exp %b/%h", rd_valid, rd_data, exp_v, last_rd); else n_pass++;
         end
      end
      drive(1'b1, 16'hC0FF, 1'b0);
      n_chk++; if (count !== 3'd2) $display("FAIL wrap_count: got %0d exp 2", count); else n_pass++;
      rst_n = 1'b0;
      wr_en = 1'b1;
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      n_chk++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL midrst_state: got %0d/%b/%b exp 0/1/0", count, empty, full); else n_pass++;
      n_chk++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) $display("FAIL midrst_rd: got %b/%h exp 0/0000", rd_valid, rd_data); else n_pass++;
      rst_n = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      drive(1'b0, 16'h0, 1'b1);
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL midrst_discard: got %b exp 0", rd_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_simultaneous();
      test_wrap_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
